// File: rtl/uart_apb_tx_queue_pkg.sv
// ---------------------------------------------------------------------------
// uart_txq_pkg
// Shared constants for the APB UART TX queue: register offsets, STATUS/CTRL
// bit positions and the drain state encoding.
// Related build macro: UART_TXQ_IRQ_EN (adds CTRL.ie and the irq output).
// ---------------------------------------------------------------------------
package uart_txq_pkg;

  // Register offsets (pAddr[3:0])
  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_CTRL   = 4'h8;

  // STATUS bit positions
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 4;
  localparam int ST_BUSY  = 5;
  localparam int ST_COUNT = 8;   // count field starts here, CNT_W bits wide

  // CTRL bit positions
  localparam int CTRL_EN  = 0;
  localparam int CTRL_CLR = 1;
  localparam int CTRL_IE  = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } txq_state_e;

endpackage

// File: rtl/uart_apb_tx_queue_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with fall-through read (o_rdata always shows the head).
// Ports:
//   i_clk, i_rst_n    clock, synchronous active-low reset
//   i_clr             synchronous flush; dominates push and pop
//   i_push, i_wdata   write request and data
//   i_pop             read request (head advances)
//   o_rdata           current head entry
//   o_full, o_empty   status flags
//   o_count           number of stored entries
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // Pointers carry one extra bit so that full and empty differ; the low AW
  // bits index the array, so addressing is DEPTH-modulo and wraps silently.
  logic [CNT_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_rd_ptr;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_empty = (o_count == '0);
  assign o_full  = (o_count == CNT_W'(DEPTH));
  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

  assign w_pop_ok  = i_pop & ~o_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push_ok = i_push & (~o_full | w_pop_ok);

  always_ff @(posedge i_clk) begin
    if (w_push_ok && !i_clr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_apb_tx_queue.sv
// ---------------------------------------------------------------------------
// uart_apb_tx_queue
// APB slave that queues CPU-written bytes and drains them one at a time into
// a UART TX serializer through a tx_start / tx_busy handshake.
// Ports:
//   pClk, pReset         clock, synchronous active-low reset
//   pSel/pEnable/pWrite  APB control (access phase = pSel & pEnable)
//   pAddr, pWdata        APB address (bits [3:0] decoded) and write data
//   pReadData            combinational read data, zero unless reading
//   tx_data, tx_start    byte and one-cycle load pulse to the serializer
//   tx_busy              serializer busy
//   irq                  level interrupt (only with UART_TXQ_IRQ_EN)
// Build macro: UART_TXQ_IRQ_EN enables CTRL.ie and the irq output.
// ---------------------------------------------------------------------------
module uart_apb_tx_queue
  import uart_txq_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int CNT_W   = $clog2(DEPTH) + 1,
  parameter int IRQ_LVL = 4
) (
  input  logic        pClk,
  input  logic        pReset,
  input  logic        pSel,
  input  logic        pEnable,
  input  logic        pWrite,
  input  logic [31:0] pAddr,
  input  logic [31:0] pWdata,
  output logic [31:0] pReadData,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        irq
);

  txq_state_e       r_state;
  logic [7:0]       r_tx_data;
  logic             r_tx_start;
  logic             r_en;
  logic             r_ovf;

  logic             w_wr;
  logic             w_data_wr;
  logic             w_status_wr;
  logic             w_ctrl_wr;
  logic             w_clr;
  logic             w_pop;
  logic             w_ovf_set;
  logic             w_ie;
  logic [7:0]       w_head;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  logic [31:0]      w_rdata;
  logic             w_unused;

  assign w_wr        = pSel & pEnable & pWrite;
  assign w_data_wr   = w_wr & (pAddr[3:0] == ADDR_DATA);
  assign w_status_wr = w_wr & (pAddr[3:0] == ADDR_STATUS);
  assign w_ctrl_wr   = w_wr & (pAddr[3:0] == ADDR_CTRL);
  assign w_clr       = w_ctrl_wr & pWdata[CTRL_CLR];
  assign w_pop       = (r_state == LOAD);
  // Drop only when full and nothing leaves this cycle (full implies non-empty,
  // so a LOAD cycle always frees a slot).
  assign w_ovf_set   = w_data_wr & w_full & ~w_pop;
  assign w_unused    = ^{pAddr[31:4], pWdata[31:8]};

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8),
    .CNT_W (CNT_W)
  ) u_fifo (
    .i_clk   (pClk),
    .i_rst_n (pReset),
    .i_clr   (w_clr),
    .i_push  (w_data_wr),
    .i_wdata (pWdata[7:0]),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Control and sticky status
  always_ff @(posedge pClk) begin
    if (!pReset) begin
      r_en  <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_en <= pWdata[CTRL_EN];
      if (w_clr || (w_status_wr && pWdata[ST_OVF])) r_ovf <= 1'b0;
      else if (w_ovf_set)                          r_ovf <= 1'b1;
    end
  end

  // Drain FSM. tx_start/tx_data are registered on the IDLE->LOAD transition,
  // so the pulse coincides with the LOAD cycle in which the head is popped.
  always_ff @(posedge pClk) begin
    if (!pReset) begin
      r_state    <= IDLE;
      r_tx_data  <= 8'h00;
      r_tx_start <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_en && !w_empty && !tx_busy) begin
            r_state    <= LOAD;
            r_tx_data  <= w_head;
            r_tx_start <= 1'b1;
          end
        end
        LOAD:      r_state <= WAIT_BUSY;
        WAIT_BUSY: if (tx_busy)  r_state <= WAIT_DONE;
        WAIT_DONE: if (!tx_busy) r_state <= IDLE;
        default:   r_state <= IDLE;
      endcase
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_start = r_tx_start;

`ifdef UART_TXQ_IRQ_EN
  logic r_ie;
  logic r_irq;

  always_ff @(posedge pClk) begin
    if (!pReset) begin
      r_ie  <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_ie <= pWdata[CTRL_IE];
      r_irq <= r_en & r_ie & (w_count <= CNT_W'(IRQ_LVL));
    end
  end

  assign w_ie = r_ie;
  assign irq  = r_irq;
`else
  logic w_unused_lvl;
  assign w_unused_lvl = (IRQ_LVL > 0);
  assign w_ie = 1'b0;
  assign irq  = 1'b0;
`endif

  // Read mux; DATA is write-only and unmapped offsets read zero.
  always_comb begin
    w_rdata = 32'h0;
    if (pSel && !pWrite) begin
      case (pAddr[3:0])
        ADDR_STATUS: begin
          w_rdata[ST_EMPTY]           = w_empty;
          w_rdata[ST_FULL]            = w_full;
          w_rdata[ST_OVF]             = r_ovf;
          w_rdata[ST_BUSY]            = (r_state != IDLE);
          w_rdata[ST_COUNT +: CNT_W]  = w_count;
        end
        ADDR_CTRL: begin
          w_rdata[CTRL_EN] = r_en;
          w_rdata[CTRL_IE] = w_ie;
        end
        default: w_rdata = 32'h0;
      endcase
    end
  end

  assign pReadData = w_rdata;

endmodule

// File: tb/tb_uart_apb_tx_queue.sv
// ---------------------------------------------------------------------------
// tb_uart_apb_tx_queue
// Directed bench for uart_apb_tx_queue with a simple serializer model that
// holds tx_busy for 10 cycles after each tx_start.
// Optional build macro: UART_TXQ_IRQ_EN (irq expectations follow it).
// ---------------------------------------------------------------------------
module tb_uart_apb_tx_queue;

  logic        pClk;
  logic        pReset;
  logic        pSel;
  logic        pEnable;
  logic        pWrite;
  logic [31:0] pAddr;
  logic [31:0] pWdata;
  logic [31:0] pReadData;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        irq;

  uart_apb_tx_queue dut (
    .pClk      (pClk),
    .pReset    (pReset),
    .pSel      (pSel),
    .pEnable   (pEnable),
    .pWrite    (pWrite),
    .pAddr     (pAddr),
    .pWdata    (pWdata),
    .pReadData (pReadData),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .irq       (irq)
  );

  initial pClk = 1'b0;
  always #5 pClk = ~pClk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge pClk) cyc <= cyc + 1;

  // Serializer model and tx_start monitor
  logic       ser_auto = 1'b1;
  logic       man_busy = 1'b0;
  logic       ser_busy = 1'b0;
  int         ser_cnt  = 0;
  int         n_start  = 0;
  int         n_fall   = 0;
  int         hold_err = 0;
  int         start_cyc [16];
  logic [7:0] start_data [16];
  int         fall_cyc [16];
  logic [7:0] last_data = 8'h00;

  assign tx_busy = ser_auto ? ser_busy : man_busy;

  always @(negedge pClk) begin
    if (tx_start) begin
      if (n_start < 16) begin
        start_cyc[n_start]  <= cyc;
        start_data[n_start] <= tx_data;
      end
      n_start   <= n_start + 1;
      last_data <= tx_data;
    end
    if (ser_busy && (tx_data !== last_data)) hold_err <= hold_err + 1;
    if (!pReset) begin
      ser_busy <= 1'b0;
      ser_cnt  <= 0;
    end else if (ser_cnt != 0) begin
      if (ser_cnt == 1) begin
        ser_busy <= 1'b0;
        if (n_fall < 16) fall_cyc[n_fall] <= cyc;
        n_fall <= n_fall + 1;
      end
      ser_cnt <= ser_cnt - 1;
    end else if (tx_start && ser_auto) begin
      ser_busy <= 1'b1;
      ser_cnt  <= 10;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns the cycle index of the access phase.
  task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output int acc);
    @(posedge pClk); #1;
    pSel = 1'b1; pEnable = 1'b0; pWrite = 1'b1; pAddr = a; pWdata = d;
    @(posedge pClk); #1;
    pEnable = 1'b1;
    acc = cyc;
    @(posedge pClk); #1;
    pSel = 1'b0; pEnable = 1'b0; pWrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    @(posedge pClk); #1;
    pSel = 1'b1; pEnable = 1'b0; pWrite = 1'b0; pAddr = a;
    @(posedge pClk); #1;
    pEnable = 1'b1;
    @(negedge pClk);
    d = pReadData;
    @(posedge pClk); #1;
    pSel = 1'b0; pEnable = 1'b0;
  endtask

  logic [31:0] rd;
  int          acc;
  int          acc1;

  initial begin
    pReset = 1'b0; pSel = 1'b0; pEnable = 1'b0; pWrite = 1'b0;
    pAddr = 32'h0; pWdata = 32'h0;
    repeat (3) @(posedge pClk);
    #1 pReset = 1'b1;

    // 1. Reset state
    apb_read(32'h4, rd);  check("reset_status", rd, 32'h0000_0001);
    apb_read(32'h8, rd);  check("reset_ctrl", rd, 32'h0);
    apb_read(32'hC, rd);  check("unmapped_read", rd, 32'h0);
    check("reset_tx_data", {24'h0, tx_data}, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    repeat (5) @(posedge pClk);
    #1 check("no_start_after_reset", n_start, 32'd0);

    // 2. Two bytes through the serializer
    apb_write(32'h8, 32'h1, acc);
    apb_read(32'h8, rd);  check("ctrl_en", rd, 32'h1);
    apb_write(32'h0, 32'h41, acc1);
    apb_write(32'h0, 32'h42, acc);
    for (int i = 0; i < 200 && !(n_start == 2 && n_fall == 2); i++) @(posedge pClk);
    #1 check("two_transfers_done", 32'(n_start == 2 && n_fall == 2), 32'd1);
    check("start_latency", start_cyc[0], acc1 + 2);
    check("byte0", {24'h0, start_data[0]}, 32'h41);
    check("byte1", {24'h0, start_data[1]}, 32'h42);
    // One idle cycle separates the cycle busy is first low from the next LOAD.
    check("restart_gap", start_cyc[1] - fall_cyc[0], 32'd2);
    apb_read(32'h4, rd);  check("status_drained", rd, 32'h0000_0001);

    // 3. Overflow with en=0
    apb_write(32'h8, 32'h0, acc);
    for (int i = 0; i < 17; i++) apb_write(32'h0, 32'h50 + i, acc);
    apb_read(32'h4, rd);  check("status_full_ovf", rd, 32'h0000_1012);
    apb_write(32'h4, 32'h10, acc);
    apb_read(32'h4, rd);  check("status_ovf_cleared", rd, 32'h0000_1002);

    // 4. en=1 then a DATA write exactly in the LOAD cycle of a full queue
    @(posedge pClk); #1;
    pSel = 1'b1; pEnable = 1'b0; pWrite = 1'b1; pAddr = 32'h8; pWdata = 32'h1;
    @(posedge pClk); #1 pEnable = 1'b1;
    @(posedge pClk); #1 pEnable = 1'b0; pAddr = 32'h0; pWdata = 32'h77;
    @(posedge pClk); #1 pEnable = 1'b1;
    @(negedge pClk);
    check("load_cycle_start", {31'h0, tx_start}, 32'h1);
    check("load_cycle_data", {24'h0, tx_data}, 32'h50);
    @(posedge pClk); #1 pSel = 1'b0; pEnable = 1'b0; pWrite = 1'b0;
    apb_read(32'h4, rd);  check("status_full_push_pop", rd, 32'h0000_1022);

    // 5. clr during WAIT_DONE of the next byte (0x51)
    for (int i = 0; i < 200 && !(ser_busy && ser_cnt == 8); i++) begin
      @(posedge pClk); #1;
    end
    check("reached_wait_done", 32'(ser_busy && ser_cnt == 8), 32'd1);
    apb_write(32'h8, 32'h3, acc);
    apb_read(32'h4, rd);  check("status_after_clr", rd, 32'h0000_0021);
    apb_read(32'h8, rd);  check("ctrl_clr_reads_0", rd, 32'h1);
    repeat (40) @(posedge pClk);
    #1 check("no_start_after_clr", n_start, 32'd4);
    check("inflight_finished", n_fall, 32'd4);
    check("tx_data_held", {24'h0, tx_data}, 32'h51);
    apb_read(32'h4, rd);  check("status_idle_after_clr", rd, 32'h0000_0001);
    check("tx_data_stable_while_busy", hold_err, 32'd0);

    // 6. Reset while in WAIT_BUSY
    ser_auto = 1'b0; man_busy = 1'b0;
    apb_write(32'h0, 32'h99, acc1);
    apb_write(32'h0, 32'h9A, acc);
    check("start_latency_2", start_cyc[4], acc1 + 2);
    check("byte_99", {24'h0, start_data[4]}, 32'h99);
    apb_read(32'h4, rd);  check("status_wait_busy", rd, 32'h0000_0120);
    @(posedge pClk); #1 pReset = 1'b0;
    @(posedge pClk); @(posedge pClk); #1 pReset = 1'b1;
    check("rst_tx_start", {31'h0, tx_start}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    apb_read(32'h4, rd);  check("rst_status", rd, 32'h0000_0001);
    apb_read(32'h8, rd);  check("rst_ctrl", rd, 32'h0);
    repeat (5) @(posedge pClk);
    #1 check("no_start_after_rst", n_start, 32'd5);

    // 7. irq threshold: count 5 -> 4 with en=1 (ie=1 where supported)
    man_busy = 1'b1;
    apb_write(32'h8, 32'h5, acc);
    apb_read(32'h8, rd);
`ifdef UART_TXQ_IRQ_EN
    check("ctrl_en_ie", rd, 32'h5);
    check("irq_empty", {31'h0, irq}, 32'h1);
`else
    check("ctrl_ie_ignored", rd, 32'h1);
    check("irq_tied_0_a", {31'h0, irq}, 32'h0);
`endif
    for (int i = 0; i < 5; i++) apb_write(32'h0, 32'hA0 + i, acc);
    @(posedge pClk); #1;
    check("irq_count5", {31'h0, irq}, 32'h0);
    apb_read(32'h4, rd);  check("status_count5", rd, 32'h0000_0500);
    man_busy = 1'b0;
    repeat (4) @(posedge pClk);
    #1;
`ifdef UART_TXQ_IRQ_EN
    check("irq_count4", {31'h0, irq}, 32'h1);
`else
    check("irq_tied_0_b", {31'h0, irq}, 32'h0);
`endif
    check("byte_A0", {24'h0, start_data[5]}, 32'hA0);
    apb_read(32'h4, rd);  check("status_count4", rd, 32'h0000_0420);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
